// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues single-cycle-latency word reads
// to instruction memory and queues the returned words for decode over valid/ready.
module instr_fetch_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [31:0]       imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic              idle
);

    localparam int               PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        START,
        FETCH,
        HALT
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] tagPc_q;
    logic              inflight_q;
    logic [PTR_W-1:0]  rdPtr_q;
    logic [PTR_W-1:0]  wrPtr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [31:0]       instrBuf_q [BUF_DEPTH];
    logic [ADDR_W-1:0] pcBuf_q    [BUF_DEPTH];

    logic              redirectTaken;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W-1:0]  occupancy;
    logic [ADDR_W-1:0] redirectTarget;

    assign redirectTaken  = redirect_valid && (state_q != START);
    assign pop            = (count_q != '0) && if_ready;
    assign push           = inflight_q && !redirectTaken;
    assign redirectTarget = redirect_pc & ~ADDR_W'(3);

    // The slot vacated by this cycle's pop counts as free, so a steady
    // if_ready stream sustains one fetch per cycle without ever overflowing.
    assign occupancy = count_q + CNT_W'(inflight_q) - CNT_W'(pop);
    assign issue     = (state_q == FETCH) && !halt && !redirectTaken && (occupancy < DEPTH_C);

    assign imem_rd   = issue;
    assign imem_addr = pc_q;
    assign if_valid  = (count_q != '0);
    assign if_instr  = if_valid ? instrBuf_q[rdPtr_q] : '0;
    assign if_pc     = if_valid ? pcBuf_q[rdPtr_q] : '0;
    assign idle      = (state_q == HALT) && !inflight_q && (count_q == '0);

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (redirectTaken) begin
            pc_d    = redirectTarget;
            count_d = '0;
        end else if (issue) begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= START;
            pc_q       <= RESET_PC;
            tagPc_q    <= RESET_PC;
            inflight_q <= 1'b0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
        end else begin
            case (state_q)
                START:   state_q <= FETCH;
                FETCH:   if (halt) state_q <= HALT;
                HALT:    if (!halt) state_q <= FETCH;
                default: state_q <= START;
            endcase

            pc_q       <= pc_d;
            count_q    <= count_d;
            inflight_q <= issue;
            if (issue) begin
                tagPc_q <= pc_q;
            end

            // A pop in the redirect cycle has already been taken by decode;
            // the flush simply discards everything that remains.
            if (redirectTaken) begin
                rdPtr_q <= '0;
                wrPtr_q <= '0;
            end else begin
                if (push) begin
                    wrPtr_q <= wrPtr_q + PTR_W'(1);
                end
                if (pop) begin
                    rdPtr_q <= rdPtr_q + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instrBuf_q[wrPtr_q] <= imem_data;
            pcBuf_q[wrPtr_q]    <= tagPc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized bench for instr_fetch_ctrl: a memory model answers reads one cycle
// later and a scoreboard of issued PCs predicts every handshake output.
module tb_instr_fetch_ctrl;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          ST_START = 0;
    localparam int          ST_FETCH = 1;
    localparam int          ST_HALT  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        idle;

    always #5 clk = ~clk;

    instr_fetch_ctrl #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC),
        .BUF_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .idle          (idle)
    );

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          sinceRel  = 0;
    logic        haltPrev  = 1'b0;
    logic [31:0] expPc     = RESET_PC;
    logic        memRdPrev = 1'b0;
    logic [31:0] memAddrPrev = '0;
    logic [31:0] pcQ[$];
    int          visibleAtQ[$];

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check mid-cycle, advance the scoreboard.
    task automatic applyStimulus(input logic rstV, input logic haltV, input logic readyV,
                                 input logic redirV, input logic [31:0] redirPc);
        int   st;
        logic expValid;
        logic popNow;
        logic redirEff;
        logic expRd;
        rst_n          = rstV;
        halt           = haltV;
        if_ready       = readyV;
        redirect_valid = redirV;
        redirect_pc    = redirPc;
        imem_data      = memRdPrev ? memWord(memAddrPrev) : $urandom;
        #4;
        memRdPrev   = imem_rd;
        memAddrPrev = imem_addr;
        if (!rstV) begin
            pcQ.delete();
            visibleAtQ.delete();
            expPc    = RESET_PC;
            sinceRel = 0;
            haltPrev = 1'b0;
        end else begin
            if (sinceRel == 0)      st = ST_START;
            else if (sinceRel == 1) st = ST_FETCH;
            else                    st = haltPrev ? ST_HALT : ST_FETCH;

            if (sinceRel == 0) begin
                checkOutput("rst_if_instr", if_instr, 32'h0);
                checkOutput("rst_if_pc", if_pc, 32'h0);
            end

            expValid = (pcQ.size() > 0) && (visibleAtQ[0] <= cyc);
            checkOutput("if_valid", {31'b0, if_valid}, {31'b0, expValid});
            if (expValid) begin
                checkOutput("if_pc", if_pc, pcQ[0]);
                checkOutput("if_instr", if_instr, memWord(pcQ[0]));
            end
            popNow   = expValid && readyV;
            redirEff = redirV && (st != ST_START);
            expRd    = (st == ST_FETCH) && !haltV && !redirEff &&
                       ((pcQ.size() - int'(popNow)) < DEPTH);
            checkOutput("imem_rd", {31'b0, imem_rd}, {31'b0, expRd});
            checkOutput("imem_addr", imem_addr, expPc);
            checkOutput("idle", {31'b0, idle}, {31'b0, (st == ST_HALT) && (pcQ.size() == 0)});

            if (popNow) begin
                void'(pcQ.pop_front());
                void'(visibleAtQ.pop_front());
            end
            if (redirEff) begin
                pcQ.delete();
                visibleAtQ.delete();
                expPc = redirPc & 32'hFFFF_FFFC;
            end else if (expRd) begin
                pcQ.push_back(expPc);
                visibleAtQ.push_back(cyc + 2);
                expPc = expPc + 32'd4;
            end
            if (pcQ.size() > DEPTH) begin
                checkOutput("credit", pcQ.size(), DEPTH);
            end
            haltPrev = haltV;
            sinceRel++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic resetCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    int haltLeft;

    initial begin
        rst_n          = 1'b0;
        halt           = 1'b0;
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_data      = '0;
        @(posedge clk);
        #1;

        // Straight-line streaming from reset.
        resetCycles(3);
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

        // Decode stalls with the first instruction at the head.
        resetCycles(2);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

        // Redirect to 0x103 while 0x10 is being fetched.
        resetCycles(2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

        // Halt for four cycles, then resume.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

        // Address wrap at the top of the space.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

        // Redirect coinciding with halt, then resume at the new target.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_2000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset in the middle of a stalled stream.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);

        haltLeft = 0;
        for (int i = 0; i < 3000; i++) begin
            logic        rV;
            logic        hV;
            logic        yV;
            logic        dV;
            logic [31:0] tV;
            if (haltLeft > 0) haltLeft--;
            else if ($urandom_range(0, 30) == 0) haltLeft = $urandom_range(1, 6);
            hV = (haltLeft > 0);
            yV = ($urandom_range(0, 3) != 0);
            dV = ($urandom_range(0, 20) == 0);
            tV = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            rV = ($urandom_range(0, 500) != 0);
            applyStimulus(rV, hV, yV, dV, tV);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
